// File: rtl/wave_voice_sched.sv
// rtl/wave_voice_sched.sv - voice allocator with priority stealing and wave-ROM slot arbiter
module wave_voice_sched #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 17
) (
  input  logic                         I_CLK,
  input  logic                         I_RST,
  input  logic                         I_REQ_VALID,
  input  logic [ADDR_W-1:0]            I_REQ_ADDR,
  input  logic [1:0]                   I_REQ_PRIO,
  output logic                         O_REQ_READY,
  output logic                         O_REQ_DROP,
  output logic [2:0]                   O_REQ_VOICE,
  input  logic                         I_STOP_ALL,
  input  logic [NUM_VOICES-1:0]        I_VOICE_ACTIVE,
  input  logic [NUM_VOICES*ADDR_W-1:0] I_VOICE_ADDR,
  output logic [NUM_VOICES-1:0]        O_TRIG,
  output logic [NUM_VOICES-1:0]        O_STOP,
  output logic [ADDR_W-1:0]            O_START_ADDR,
  output logic [3:0]                   O_H_CNT,
  output logic [ADDR_W-1:0]            O_ROM_ADDR
);
  typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_TRIG, S_GAP} state_t;

  state_t                state_q;
  logic                  phase_q;
  logic                  idle_q;
  logic [ADDR_W-1:0]     req_addr_q;
  logic [1:0]            req_prio_q;
  logic                  drop_q;
  logic [2:0]            voice_q;
  logic [ADDR_W-1:0]     start_addr_q;
  logic [NUM_VOICES-1:0] trig_q;
  logic [NUM_VOICES-1:0] stop_q;
  logic [NUM_VOICES-1:0] act_q;
  logic [NUM_VOICES-1:0] resv_q;
  logic [1:0]            prio_q [NUM_VOICES];
  logic [2:0]            rtmr_q [NUM_VOICES];
  logic [3:0]            h_cnt_q;

  logic                  handshake_d;
  logic [NUM_VOICES-1:0] busy_d;
  logic                  alloc_ok_d;
  logic [2:0]            alloc_idx_d;
  logic [NUM_VOICES-1:0] alloc_hot_d;

  // READY is gated combinationally by STOP_ALL so a stop wins over a same-cycle handshake
  assign O_REQ_READY  = idle_q & ~I_STOP_ALL;
  assign handshake_d  = I_REQ_VALID & O_REQ_READY;
  assign busy_d       = act_q | resv_q;
  assign O_REQ_DROP   = drop_q;
  assign O_REQ_VOICE  = voice_q;
  assign O_START_ADDR = start_addr_q;
  assign O_TRIG       = trig_q;
  assign O_STOP       = stop_q;
  assign O_H_CNT      = h_cnt_q;

  // Lowest free voice first; otherwise the lowest-priority busy voice below the request priority
  always_comb begin
    logic       free_found;
    logic [2:0] free_idx;
    logic       vict_found;
    logic [2:0] vict_idx;
    logic [1:0] vict_prio;
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!busy_d[v]) begin
        free_found = 1'b1;
        free_idx   = 3'(v);
      end
    end
    vict_found = 1'b0;
    vict_idx   = 3'd0;
    vict_prio  = 2'd0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (busy_d[v] && (prio_q[v] < req_prio_q) && (!vict_found || (prio_q[v] < vict_prio))) begin
        vict_found = 1'b1;
        vict_idx   = 3'(v);
        vict_prio  = prio_q[v];
      end
    end
    alloc_ok_d  = free_found | vict_found;
    alloc_idx_d = free_found ? free_idx : vict_idx;
    alloc_hot_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      alloc_hot_d[v] = alloc_ok_d && (alloc_idx_d == 3'(v));
    end
  end

  // ROM address follows the voice owning the current slot pair; unused slots read address 0
  always_comb begin
    O_ROM_ADDR = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (h_cnt_q[3:1] == 3'(v)) O_ROM_ADDR = I_VOICE_ADDR[v*ADDR_W +: ADDR_W];
    end
  end

  // Free-running slot counter, registered stop broadcast and sampled voice activity
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      h_cnt_q <= 4'd0;
      stop_q  <= '0;
      act_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_q + 4'd1;
      stop_q  <= {NUM_VOICES{I_STOP_ALL}};
      act_q   <= I_VOICE_ACTIVE;
    end
  end

  // Request FSM: IDLE -> ALLOC -> TRIG(2) -> GAP(2) -> IDLE, or ALLOC -> IDLE on a drop
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      idle_q       <= 1'b0;
      req_addr_q   <= '0;
      req_prio_q   <= 2'd0;
      drop_q       <= 1'b0;
      voice_q      <= 3'd0;
      start_addr_q <= '0;
      trig_q       <= '0;
      for (int v = 0; v < NUM_VOICES; v++) prio_q[v] <= 2'd0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (handshake_d) begin
            req_addr_q <= I_REQ_ADDR;
            req_prio_q <= I_REQ_PRIO;
            idle_q     <= 1'b0;
            state_q    <= S_ALLOC;
          end else begin
            idle_q <= 1'b1;
          end
        end
        S_ALLOC: begin
          if (alloc_ok_d) begin
            voice_q      <= alloc_idx_d;
            start_addr_q <= req_addr_q;
            trig_q       <= alloc_hot_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (alloc_hot_d[v]) prio_q[v] <= req_prio_q;
            end
            phase_q <= 1'b0;
            state_q <= S_TRIG;
          end else begin
            drop_q  <= 1'b1;
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_TRIG: begin
          if (phase_q) begin
            trig_q  <= '0;
            phase_q <= 1'b0;
            state_q <= S_GAP;
          end else begin
            phase_q <= 1'b1;
          end
        end
        S_GAP: begin
          if (phase_q) begin
            phase_q <= 1'b0;
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            phase_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reservation covers the gap until the player raises ACTIVE; gives up after 7 busy cycles
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      resv_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) rtmr_q[v] <= 3'd0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if ((state_q == S_ALLOC) && alloc_hot_d[v]) begin
          resv_q[v] <= 1'b1;
          rtmr_q[v] <= 3'd0;
        end else if (resv_q[v]) begin
          if (I_VOICE_ACTIVE[v] || (rtmr_q[v] == 3'd6)) begin
            resv_q[v] <= 1'b0;
            rtmr_q[v] <= 3'd0;
          end else begin
            rtmr_q[v] <= rtmr_q[v] + 3'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_wave_voice_sched.sv
// tb/tb_wave_voice_sched.sv - scoreboard bench for wave_voice_sched
`timescale 1ns/1ps
module tb_wave_voice_sched;
  localparam int NV = 4;
  localparam int AW = 17;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [1:0]       req_prio = 2'd0;
  logic             ready;
  logic             drop;
  logic [2:0]       voice;
  logic             stop_all = 1'b0;
  logic [NV-1:0]    voice_active;
  logic [NV*AW-1:0] voice_addr;
  logic [NV-1:0]    trig;
  logic [NV-1:0]    stop;
  logic [AW-1:0]    start_addr;
  logic [3:0]       h_cnt;
  logic [AW-1:0]    rom_addr;

  logic [NV-1:0]    act_drv = '0;
  logic [NV-1:0]    auto_act = '1;
  logic [NV-1:0]    hold_act = '0;
  int               cyc = 0;
  int               n_vec = 0;
  int               n_err = 0;
  logic [AW-1:0]    rom_exp [8];

  typedef struct {
    logic          drop;
    logic [2:0]    voice;
    logic [AW-1:0] addr;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  assign voice_active = act_drv | hold_act;
  assign voice_addr   = {17'h00400, 17'h00300, 17'h00200, 17'h00100};

  wave_voice_sched #(.NUM_VOICES(NV), .ADDR_W(AW)) dut (
    .I_CLK(clk), .I_RST(rst),
    .I_REQ_VALID(req_valid), .I_REQ_ADDR(req_addr), .I_REQ_PRIO(req_prio),
    .O_REQ_READY(ready), .O_REQ_DROP(drop), .O_REQ_VOICE(voice),
    .I_STOP_ALL(stop_all), .I_VOICE_ACTIVE(voice_active), .I_VOICE_ADDR(voice_addr),
    .O_TRIG(trig), .O_STOP(stop), .O_START_ADDR(start_addr),
    .O_H_CNT(h_cnt), .O_ROM_ADDR(rom_addr)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for READY, queues the expected outcome, returns at the negedge after the handshake
  task automatic send(input logic [AW-1:0] a, input logic [1:0] p, input logic d, input logic [2:0] v);
    exp_t e;
    int   t;
    t = 0;
    while (!ready && t < 40) begin @(negedge clk); t = t + 1; end
    if (!ready) begin
      chk("ready_wait", 32'(ready), 1);
      return;
    end
    e.drop = d; e.voice = v; e.addr = a; e.cyc = cyc + 2;
    exp_q.push_back(e);
    req_valid = 1'b1; req_addr = a; req_prio = p;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at handshake+1: READY low through GAP, START_ADDR stable during TRIG/GAP, READY back at +6
  task automatic chk_busy(input logic [AW-1:0] a);
    for (int k = 1; k <= 5; k++) begin
      chk("ready_busy", 32'(ready), 0);
      if (k >= 2) chk("start_addr_stable", 32'(start_addr), 32'(a));
      @(negedge clk);
    end
    chk("ready_back", 32'(ready), 1);
  endtask

  task automatic do_reset(input logic [NV-1:0] a, input logic [NV-1:0] h);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    auto_act = a; hold_act = h;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every trigger rise or drop pulse, checks trigger width, models players
  initial begin : monitor
    exp_t          e;
    logic [NV-1:0] prev;
    logic [NV-1:0] ev;
    int            len;
    bit            in_trig;
    prev = '0; len = 0; in_trig = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = '0; in_trig = 0; len = 0; act_drv = '0;
      end else begin
        if (trig != '0 && prev == '0) begin
          if (exp_q.size() == 0) begin
            n_vec = n_vec + 1; n_err = n_err + 1;
            $display("FAIL unexpected_trig: got %b, expected no trigger", trig);
          end else begin
            e = exp_q.pop_front();
            ev = '0;
            if (!e.drop) ev[e.voice[1:0]] = 1'b1;
            chk("trig_vec", 32'(trig), 32'(ev));
            chk("req_voice", 32'(voice), 32'(e.voice));
            chk("start_addr", 32'(start_addr), 32'(e.addr));
            chk("trig_cycle", 32'(cyc), 32'(e.cyc));
          end
          in_trig = 1; len = 1;
        end else if (in_trig && trig != '0) begin
          len = len + 1;
        end else if (in_trig) begin
          chk("trig_len", 32'(len), 2);
          in_trig = 0;
        end
        if (drop) begin
          if (exp_q.size() == 0) begin
            n_vec = n_vec + 1; n_err = n_err + 1;
            $display("FAIL unexpected_drop: got drop pulse, expected none");
          end else begin
            e = exp_q.pop_front();
            chk("drop_pulse", 32'(drop), 32'(e.drop));
            chk("drop_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        for (int v = 0; v < NV; v++) if (trig[v] && auto_act[v]) act_drv[v] = 1'b1;
        prev = trig;
      end
    end
  end

  initial begin
    rom_exp[0] = 17'h00100; rom_exp[1] = 17'h00200; rom_exp[2] = 17'h00300; rom_exp[3] = 17'h00400;
    rom_exp[4] = 17'h0;     rom_exp[5] = 17'h0;     rom_exp[6] = 17'h0;     rom_exp[7] = 17'h0;

    // Reset values, then slot counter wrap and ROM mux
    @(negedge clk); @(negedge clk);
    chk("rst_h_cnt", 32'(h_cnt), 0);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_stop", 32'(stop), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_voice", 32'(voice), 0);
    chk("rst_start", 32'(start_addr), 0);
    chk("rst_rom", 32'(rom_addr), 32'h00100);
    rst = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      chk("h_cnt", 32'(h_cnt), 32'(i % 16));
      chk("rom_addr", 32'(rom_addr), 32'(rom_exp[(i % 16) / 2]));
      @(negedge clk);
    end

    // Single request on idle voices
    send(17'h01000, 2'd1, 1'b0, 3'd0);
    chk_busy(17'h01000);

    // Async reset in the middle of a trigger
    send(17'h02000, 2'd2, 1'b0, 3'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_trig", 32'(trig), 0);
    chk("midrst_h_cnt", 32'(h_cnt), 0);
    chk("midrst_voice", 32'(voice), 0);
    chk("midrst_start", 32'(start_addr), 0);
    chk("midrst_ready", 32'(ready), 0);
    chk("midrst_stop", 32'(stop), 0);
    chk("midrst_rom", 32'(rom_addr), 32'h00100);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Fill all voices, steal the lowest priority, drop, then tie-break steal
    do_reset(4'hF, 4'h0);
    send(17'h10000, 2'd1, 1'b0, 3'd0);
    send(17'h11000, 2'd0, 1'b0, 3'd1);
    send(17'h12000, 2'd2, 1'b0, 3'd2);
    send(17'h13000, 2'd1, 1'b0, 3'd3);
    send(17'h1F000, 2'd3, 1'b0, 3'd1);
    send(17'h1E000, 2'd0, 1'b1, 3'd0);
    send(17'h1D000, 2'd2, 1'b0, 3'd0);

    // Reservation timeout: voice 2 never goes active, voice 3 held by its player
    do_reset(4'b1011, 4'b1000);
    send(17'h00A00, 2'd1, 1'b0, 3'd0);
    send(17'h00B00, 2'd1, 1'b0, 3'd1);
    send(17'h00C00, 2'd1, 1'b0, 3'd2);
    send(17'h00D00, 2'd0, 1'b1, 3'd0);
    send(17'h00E00, 2'd0, 1'b0, 3'd2);

    // STOP_ALL during a trigger
    repeat (12) @(negedge clk);
    send(17'h05000, 2'd1, 1'b0, 3'd2);
    @(negedge clk);
    stop_all = 1'b1;
    #1 chk("ready_in_stop", 32'(ready), 0);
    @(negedge clk);
    chk("stop_vec", 32'(stop), 32'hF);
    repeat (4) @(negedge clk);
    chk("ready_stop_idle", 32'(ready), 0);
    chk("start_addr_hold", 32'(start_addr), 32'h05000);
    req_valid = 1'b1; req_addr = 17'h06000; req_prio = 2'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ready_held_low", 32'(ready), 0);
    end
    req_valid = 1'b0; stop_all = 1'b0;
    #1 chk("ready_after_stop", 32'(ready), 1);
    @(negedge clk);
    chk("stop_clear", 32'(stop), 0);
    req_valid = 1'b1; stop_all = 1'b1;
    #1 chk("ready_stop_same_cycle", 32'(ready), 0);
    @(negedge clk);
    req_valid = 1'b0; stop_all = 1'b0;
    repeat (10) @(negedge clk);
    chk("exp_queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
